// File: rtl/store_trace_buffer_pkg.sv
// Shared types for the store trace buffer.
// Record layout and default FIFO depth.
package store_trace_buffer_pkg;

  typedef logic        u1;
  typedef logic [31:0] u32;

  typedef struct packed {
    u32 addr;
    u32 data;
    u32 pc;
  } store_rec_t;

  localparam int STORE_TRACE_DEPTH = 8;
  localparam int REC_W = $bits(store_rec_t);

endpackage

// File: rtl/store_trace_buffer_sync_fifo.sv
// Generic circular FIFO with separate level counter.
// Output falls through from registered storage, zero when empty.
module sync_fifo #(
  parameter int W     = 96,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // a pop in the same cycle frees the slot a full push needs
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[head];

  always_ff @(posedge clk) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      level <= '0;
    end else begin
      if (do_push) tail <= tail + AW'(1);
      if (do_pop)  head <= head + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[tail] <= din;
  end

endmodule

// File: rtl/store_trace_buffer.sv
// Captures one record per CPU store event into a FIFO, counts drops.
// STORE_TRACE_TIMESTAMP_EN adds a cycle timestamp per record.
module store_trace_buffer
  import store_trace_buffer_pkg::*;
#(
  parameter int DEPTH = STORE_TRACE_DEPTH,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   memwrite,
  input  logic [31:0]            dataaddr,
  input  logic [31:0]            writedata,
  input  logic [31:0]            pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_addr,
  output logic [31:0]            out_data,
  output logic [31:0]            out_pc,
  output logic [CNT_W-1:0]       out_cycle,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [CNT_W-1:0]       drop_cnt
);

`ifdef STORE_TRACE_TIMESTAMP_EN
  localparam int W = REC_W + CNT_W;
`else
  localparam int W = REC_W;
`endif

  u1          mw_q;
  u1          store_ev;
  u1          pop;
  u1          full;
  u1          empty;
  u1          drop;
  store_rec_t rec;
  store_rec_t head;
  logic [W-1:0] din;
  logic [W-1:0] dout;

  assign store_ev  = memwrite & ~mw_q;
  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;
  assign drop      = store_ev & full & ~pop;
  assign rec       = '{addr: dataaddr, data: writedata, pc: pc};

  // history follows the strobe through reset: a store held across release is not new
  always_ff @(posedge clk) mw_q <= memwrite;

  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

`ifdef STORE_TRACE_TIMESTAMP_EN
  logic [CNT_W-1:0] cycle_cnt;

  always_ff @(posedge clk) begin
    if (!reset) cycle_cnt <= '0;
    else        cycle_cnt <= cycle_cnt + CNT_W'(1);
  end

  assign din = {cycle_cnt, rec};
  assign {out_cycle, head} = dout;
`else
  assign din       = rec;
  assign head      = dout;
  assign out_cycle = '0;
`endif

  assign out_addr = head.addr;
  assign out_data = head.data;
  assign out_pc   = head.pc;

  sync_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (store_ev),
    .pop   (pop),
    .din   (din),
    .dout  (dout),
    .full  (full),
    .empty (empty),
    .level (level)
  );

endmodule
